// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg
// Shared definitions for the two-master RAM arbiter: FSM state encoding,
// master identifiers and the latency counter width.
// Revision: 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_ACCESS = ST_ACCESS,
      S_WAIT   = ST_WAIT,
      S_DONE   = ST_DONE
   } state_t;

   // Master identifiers, also used as gnt_id / last_gnt values
   localparam logic M_CPU = 1'b0;
   localparam logic M_LDR = 1'b1;

   // Wide enough for the largest legal read latency (7)
   localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arb_rr2.sv
`default_nettype none
// ============================================================================
// mem_arb_rr2
// Combinational two-way round-robin picker.
// Ports:
//   req[1:0]  request vector, bit index = master ID
//   last_gnt  master granted most recently
//   valid     at least one request present
//   winner    ID of the selected master (meaningful only when valid)
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_rr2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       valid,
   output logic       winner
);

   always_comb begin
      valid  = |req;
      winner = M_CPU;
      if (&req) begin
         // Tie: the master that did not win last time goes first
         winner = ~last_gnt;
      end else if (req[M_LDR]) begin
         winner = M_LDR;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter
// Round-robin arbiter giving the CPU (m0) and loader (m1) access to a single
// port synchronous RAM. One read or write per req/ack handshake; every access
// takes IDLE -> ACCESS -> WAIT (RAM_LAT cycles) -> DONE, with ack in DONE.
// Ports:
//   clk_qzt, reset            clock, asynchronous active-high reset
//   m*_req/we/addr/wdata      master request bus (held until ack)
//   m*_ack, m*_rdata          one-cycle completion pulse, registered read data
//   ram_addr/wdata/we/rdata   RAM macro interface
//   busy, gnt_id              FSM not idle, current/last granted master
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int RAM_LAT = 1
)(
   input  logic              clk_qzt,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              gnt_id
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RAM_LAT);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_gnt;
   logic             cur_we;     // direction of the transaction in flight
   logic             pick_valid;
   logic             pick_winner;

   mem_arb_rr2 u_pick (
      .req      ({m1_req, m0_req}),
      .last_gnt (last_gnt),
      .valid    (pick_valid),
      .winner   (pick_winner)
   );

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk_qzt or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         last_gnt  <= M_LDR;    // so the CPU wins the first tie
         gnt_id    <= M_CPU;
         cur_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  gnt_id   <= pick_winner;
                  last_gnt <= pick_winner;
                  if (pick_winner == M_LDR) begin
                     ram_addr  <= m1_addr;
                     ram_wdata <= m1_wdata;
                     ram_we    <= m1_we;
                     cur_we    <= m1_we;
                  end else begin
                     ram_addr  <= m0_addr;
                     ram_wdata <= m0_wdata;
                     ram_we    <= m0_we;
                     cur_we    <= m0_we;
                  end
                  state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // Write strobe lives for the ACCESS cycle only
               ram_we <= 1'b0;
               cnt    <= LAT_LOAD;
               state  <= S_WAIT;
            end
            S_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               // Count of 1 marks the cycle in which ram_rdata is valid
               if (cnt == CNT_W'(1)) begin
                  if (gnt_id == M_LDR) begin
                     m1_ack <= 1'b1;
                     if (!cur_we) m1_rdata <= ram_rdata;
                  end else begin
                     m0_ack <= 1'b1;
                     if (!cur_we) m0_rdata <= ram_rdata;
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the single-port 256x8 synchronous RAM shared by the CPU core and the program loader/debug port. Each master issues one read or write per request/acknowledge handshake; the arbiter grants round-robin, sequences the RAM address, data and write strobe, and returns read data registered with a one-cycle acknowledge. It sits between the CPU's data_addr/data_out/write_en bus, the loader, and the RAM macro.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, data width
- RAM_LAT, 1, RAM read latency in cycles from address sampled to ram_rdata valid; legal range 1..7
- clk_qzt  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- m0_req  input  1  CPU request, held until m0_ack
- m0_we  input  1  CPU write (1) / read (0), stable while m0_req
- m0_addr  input  ADDR_W  CPU address, stable while m0_req
- m0_wdata  input  DATA_W  CPU write data, stable while m0_req
- m0_ack  output  1  one-cycle completion pulse to CPU
- m0_rdata  output  DATA_W  CPU read data, valid from m0_ack onward
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: loader master, same widths and rules as m0
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  RAM write data
- ram_we  output  1  RAM write strobe
- ram_rdata  input  DATA_W  RAM read data
- busy  output  1  high in any state other than IDLE
- gnt_id  output  1  master owning the current or last transaction (debug)

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: if any req high, pick winner, latch its we/addr/wdata into ram_addr/ram_wdata/ram_we, set gnt_id, go ACCESS. Otherwise stay.
- Pick rule: one requester wins; both requesting, the master not granted last wins (last_gnt register, updated on each grant).
- ACCESS: ram_we high for this single cycle only (write); load counter with RAM_LAT; go WAIT.
- WAIT: decrement counter; when counter equals 1, capture ram_rdata into winner's rdata register (reads only), assert winner's ack register, go DONE.
- DONE: ack high exactly this cycle; go IDLE.
- Writes traverse WAIT/DONE too, for uniform latency; m*_rdata is not modified by writes.
- Requester clears req on the edge where it sees ack high; req sampled in IDLE is therefore a new request.
- req dropped mid-transaction: transaction still completes and ack still pulses.
- ram_addr/ram_wdata hold their last values outside ACCESS; ram_we is 0 in all states except ACCESS with a write.

## Timing
- Reset values: state IDLE, all acks 0, m0_rdata/m1_rdata 0, ram_addr 0, ram_wdata 0, ram_we 0, busy 0, gnt_id 0, last_gnt 1 (so m0 wins the first tie), counter 0.
- Reset mid-transaction: abort immediately to reset values; no ack issued, pending write may or may not reach RAM.
- req seen in IDLE at cycle 0 → ACCESS cycle 1 → WAIT cycles 2..RAM_LAT+1 → DONE (ack) cycle RAM_LAT+2 → IDLE cycle RAM_LAT+3.
- Per-access occupancy RAM_LAT+3 cycles; back-to-back grant of a waiting master at ACCESS cycle RAM_LAT+4.
- Both masters continuously requesting: grants strictly alternate m0, m1, m0, …; neither starves.

## Structure
- Shared package: state encoding localparams (IDLE=0, ACCESS=1, WAIT=2, DONE=3), master-ID constants M_CPU=0, M_LDR=1.
- One sub-module: mem_arb_rr2, combinational two-way round-robin picker (inputs req[1:0], last_gnt; outputs valid, winner). Counter, FSM and datapath registers stay in mem_arbiter.

## Test plan
- Reset then m0 read addr 0x10 (RAM holds 0x3C), RAM_LAT=1 → ram_addr=0x10 at cycle 1, m0_ack at cycle 3, m0_rdata=0x3C, m1_ack stays 0.
- m1 write addr 0xFF data 0xA5 → ram_we high exactly one cycle with ram_addr=0xFF, ram_wdata=0xA5; m1_ack at cycle 3; subsequent m0 read of 0xFF returns 0xA5; m1_rdata unchanged.
- m0 and m1 request same cycle after reset, both held → grant order m0, m1, m0, m1 across four accesses, grants 4 cycles apart.
- RAM_LAT=3, m0 read → m0_ack at cycle 5; busy high cycles 1..5.
- m0 drops req during WAIT → m0_ack still pulses once at cycle 3, no second transaction starts.
- reset asserted during WAIT of an m1 read → next cycle all outputs at reset values, no m1_ack; after release m0 wins a tie.
